instr_encoder_loader: RTL and testbench

- Inverse of the CPU's main/ALU decoder: accepts symbolic instruction fields over a valid/ready handshake and encodes them into RV32I machine words.
- Covers the supported subset: lw, sw, add, sub, slt, or, and, beq.
- Writes each word sequentially into instruction memory, so test programs can be loaded into the single-cycle CPU without a hex file.
- Sits between the bench/UART front-end and the instruction-memory write port.

---
 rtl/instr_enc_pkg.sv | 41 ++++
 rtl/rv_word_encoder.sv | 35 +++
 rtl/instr_encoder_loader.sv | 139 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared encodings for the RV32I instruction loader: symbolic kinds, opcode/funct fields, FSM states.
// No logic here; imported by the encoder and the loader FSM.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    K_LW  = 4'd0,
    K_SW  = 4'd1,
    K_ADD = 4'd2,
    K_SUB = 4'd3,
    K_SLT = 4'd4,
    K_OR  = 4'd5,
    K_AND = 4'd6,
    K_BEQ = 4'd7
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ENCODE,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/rv_word_encoder.sv
// Combinational RV32I word builder for the supported subset; flags unknown kinds and odd branch offsets.
// Zero latency, no handshake.
module rv_word_encoder
  import instr_enc_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_LW:  word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
      K_SW:  word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
      K_ADD: word = {F7_BASE, rs2, rs1, F3_ADD, rd, OP_RTYPE};
      K_SUB: word = {F7_SUB,  rs2, rs1, F3_SUB, rd, OP_RTYPE};
      K_SLT: word = {F7_BASE, rs2, rs1, F3_SLT, rd, OP_RTYPE};
      K_OR:  word = {F7_BASE, rs2, rs1, F3_OR,  rd, OP_RTYPE};
      K_AND: word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_RTYPE};
      K_BEQ: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        // Branch offsets are halfword multiples; bit 0 cannot be encoded.
        illegal = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction bundles, encodes them to RV32I and writes them sequentially to imem.
// 3 cycles per bundle (accept, encode, write); in_ready low outside ACCEPT, so the source stalls.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_INSTR = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-2:0] count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-2:0] MAX_CNT = (ADDR_W-1)'(MAX_INSTR);

  state_e      state;
  logic [3:0]  cap_kind;
  logic [4:0]  cap_rd, cap_rs1, cap_rs2;
  logic [12:0] cap_imm;
  logic        cap_last;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic [ADDR_W-2:0] count_inc;

  assign count_inc = count + 1'b1;

  rv_word_encoder u_enc (
    .kind    (cap_kind),
    .rd      (cap_rd),
    .rs1     (cap_rs1),
    .rs2     (cap_rs2),
    .imm     (cap_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cap_kind  <= '0;
      cap_rd    <= '0;
      cap_rs1   <= '0;
      cap_rs2   <= '0;
      cap_imm   <= '0;
      cap_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ACCEPT;
            count    <= '0;
            err      <= 1'b0;
            mem_addr <= BASE;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (in_valid && in_ready) begin
            cap_kind <= in_kind;
            cap_rd   <= in_rd;
            cap_rs1  <= in_rs1;
            cap_rs2  <= in_rs2;
            cap_imm  <= in_imm;
            cap_last <= in_last;
            in_ready <= 1'b0;
            state    <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          mem_wdata <= enc_word;
          if (enc_illegal) begin
            err <= 1'b1;
            if (cap_last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_ACCEPT;
              in_ready <= 1'b1;
            end
          end else begin
            state    <= S_WRITE;
            mem_we   <= 1'b1;
            // count < MAX_INSTR <= 2^(ADDR_W-2), so the dropped top bit is always zero.
            mem_addr <= BASE + {count[ADDR_W-3:0], 2'b00};
          end
        end
        S_WRITE: begin
          mem_we <= 1'b0;
          count  <= count_inc;
          if (cap_last || count_inc == MAX_CNT) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (clear) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed + randomized bench for instr_encoder_loader against a field-level encoding model.
module tb_instr_encoder_loader;

  logic        clk, rst;
  logic        start, clear, in_valid, in_last;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;

  logic        start2, clear2, valid2;
  logic        ready2, we2, busy2, done2, err2;
  logic [7:0]  addr2;
  logic [31:0] wdata2;
  logic [6:0]  count2;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_q2[$];

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'h40), .MAX_INSTR(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .clear(clear2),
    .in_valid(valid2), .in_ready(ready2), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .count(count2), .busy(busy2), .done(done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding assembled from the RV32I field layout with shifts and ORs.
  function automatic logic [31:0] model_word(input int k, input int rd, input int rs1,
                                             input int rs2, input logic [12:0] imm);
    int f3, f7;
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15);
    case (k)
      0: return (32'(imm[11:0]) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
      1: return (32'(imm[11:5]) << 25) | regs | (32'd2 << 12) | (32'(imm[4:0]) << 7) | 32'h23;
      7: return (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25) | regs |
                (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
      default: begin
        f7 = (k == 3) ? 32 : 0;
        f3 = (k == 4) ? 2 : (k == 5) ? 6 : (k == 6) ? 7 : 0;
        return (32'(f7) << 25) | regs | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [39:0] w;
    if (mem_we) begin
      if (exp_q.size() == 0) check("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        w = exp_q.pop_front();
        check("we_addr", 32'(mem_addr), 32'(w[39:32]));
        check("we_data", mem_wdata, w[31:0]);
      end
    end
    if (we2) begin
      if (exp_q2.size() == 0) check("unexpected_we2", 32'(addr2), 32'hFFFF_FFFF);
      else begin
        w = exp_q2.pop_front();
        check("we2_addr", 32'(addr2), 32'(w[39:32]));
        check("we2_data", wdata2, w[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input bit which, input int k, input int rd, input int rs1, input int rs2,
                      input logic [12:0] imm, input logic last);
    bit ok;
    ok = 1'b0;
    in_kind = 4'(k); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm; in_last = last;
    if (which) valid2 = 1'b1; else in_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (which ? ready2 : in_ready) begin
        tick();
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    valid2 = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input bit which);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = which ? done2 : done;
    end
    check("done_reached", 32'(seen), 32'd1);
  endtask

  task automatic run_random_session(input int n);
    int cnt, k, rd, rs1, rs2;
    bit e, legal, last;
    logic [12:0] imm;
    cnt = 0;
    e = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k > 7) k = $urandom_range(8, 15);
      rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      imm = 13'($urandom);
      if (k == 7 && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
      last = (i == n - 1);
      legal = (k < 8) && !(k == 7 && imm[0]);
      if (legal) begin
        exp_q.push_back({8'(4 * cnt), model_word(k, rd, rs1, rs2, imm)});
        cnt++;
      end else e = 1'b1;
      send(1'b0, k, rd, rs1, rs2, imm, last);
    end
    wait_done(1'b0);
    check("rnd_count", 32'(count), 32'(cnt));
    check("rnd_err", 32'(err), 32'(e));
    check("rnd_busy", 32'(busy), 32'd0);
    check("rnd_ready", 32'(in_ready), 32'd0);
    check("rnd_pending", 32'(exp_q.size()), 32'd0);
    pulse_clear();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    start2 = 1'b0; clear2 = 1'b0; valid2 = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr2", 32'(addr2), 32'h40);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single ADD, write strobe two cycles after the handshake
    pulse_start(1'b0);
    check("accept_ready", 32'(in_ready), 32'd1);
    check("accept_busy", 32'(busy), 32'd1);
    exp_q.push_back({8'h00, 32'h002081B3});
    send(1'b0, 2, 3, 1, 2, 13'd0, 1'b1);
    @(negedge clk);
    check("encode_no_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("write_we", 32'(mem_we), 32'd1);
    wait_done(1'b0);
    check("add_count", 32'(count), 32'd1);
    check("add_busy", 32'(busy), 32'd0);
    check("add_err", 32'(err), 32'd0);
    pulse_clear();
    @(negedge clk);
    check("clear_done", 32'(done), 32'd0);

    // SUB, LW, SW stream
    pulse_start(1'b0);
    exp_q.push_back({8'h00, 32'h407302B3});
    exp_q.push_back({8'h04, 32'h00812203});
    exp_q.push_back({8'h08, 32'h00512623});
    send(1'b0, 3, 5, 6, 7, 13'd0, 1'b0);
    send(1'b0, 0, 4, 2, 0, 13'd8, 1'b0);
    send(1'b0, 1, 0, 2, 5, 13'd12, 1'b1);
    wait_done(1'b0);
    check("stream_count", 32'(count), 32'd3);
    check("stream_pending", 32'(exp_q.size()), 32'd0);
    pulse_clear();

    // BEQ negative offset, then odd offset rejected
    pulse_start(1'b0);
    exp_q.push_back({8'h00, 32'hFE208EE3});
    send(1'b0, 7, 0, 1, 2, 13'h1FFC, 1'b0);
    send(1'b0, 7, 0, 1, 2, 13'd3, 1'b1);
    wait_done(1'b0);
    check("beq_err", 32'(err), 32'd1);
    check("beq_count", 32'(count), 32'd1);
    pulse_clear();

    // Illegal kind, then start+clear together (clear wins), then a fresh session
    pulse_start(1'b0);
    send(1'b0, 9, 1, 1, 1, 13'd0, 1'b1);
    wait_done(1'b0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_count", 32'(count), 32'd0);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("clrwin_done", 32'(done), 32'd0);
    check("clrwin_ready", 32'(in_ready), 32'd0);
    check("clrwin_busy", 32'(busy), 32'd0);
    pulse_start(1'b0);
    check("restart_err", 32'(err), 32'd0);
    check("restart_count", 32'(count), 32'd0);
    check("restart_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({8'h00, 32'h0062E233});
    send(1'b0, 5, 4, 5, 6, 13'd0, 1'b1);
    wait_done(1'b0);
    pulse_clear();

    // MAX_INSTR=2 instance, non-zero base: third bundle must stall
    pulse_start(1'b1);
    exp_q2.push_back({8'h40, 32'h002081B3});
    exp_q2.push_back({8'h44, 32'h0020F1B3});
    send(1'b1, 2, 3, 1, 2, 13'd0, 1'b0);
    send(1'b1, 6, 3, 1, 2, 13'd0, 1'b0);
    wait_done(1'b1);
    check("max_count", 32'(count2), 32'd2);
    check("max_pending", 32'(exp_q2.size()), 32'd0);
    in_last = 1'b0;
    valid2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("max_ready_low", 32'(ready2), 32'd0);
    end
    valid2 = 1'b0;

    // Reset asserted during the WRITE cycle
    pulse_start(1'b0);
    exp_q.push_back({8'h00, 32'h00812203});
    send(1'b0, 0, 4, 2, 0, 13'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_done2", 32'(done2), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_ready", 32'(in_ready), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);
    end
    tick();

    for (int s = 0; s < 12; s++) run_random_session($urandom_range(1, 8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
